init_frame_serializer: RTL and testbench
========================================

INIT_FRAME_SERIALIZER -- requirements
Module: init_frame_serializer

Interface
REQ-001 SHALL have parameter INIT_WIDTH, default 64, giving the INIT vector width; legal values are multiples of 16 from 16 to 256.
REQ-002 SHALL have parameter SWAP_BYTES, default 1: 1 = byte-swap each 16-bit word, 0 = pass each word unchanged.
REQ-003 SHALL define the derived constants NUM_WORDS = INIT_WIDTH/16 and IDX_W = max(1, clog2(NUM_WORDS)).
REQ-004 Clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Rst  input  1  reset, asynchronous and active-high.
REQ-006 Start  input  1  single-cycle request to capture INIT and begin a transfer.
REQ-007 INIT  input  INIT_WIDTH  LUT/BRAM INIT vector to convert to frame words.
REQ-008 Order  input  1  0 = most-significant word first, 1 = least-significant word first; sampled with Start.
REQ-009 Word_out  output  16  current frame word.
REQ-010 Word_valid  output  1  Word_out and Word_idx are valid.
REQ-011 Word_ready  input  1  the consumer accepts Word_out this cycle.
REQ-012 Word_idx  output  IDX_W  sequence position (0..NUM_WORDS-1) of Word_out.
REQ-013 Last  output  1  Word_out is the final word of the transfer.
REQ-014 Busy  output  1  a transfer is in progress.
REQ-015 Done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-016 SHALL define source word k (k = 0 is most significant) as S[k] = INIT[INIT_WIDTH-1-16k -: 16].
REQ-017 With SWAP_BYTES=1, frame word F[k] SHALL be {S[k][7:0], S[k][15:8]}; with SWAP_BYTES=0, F[k] SHALL be S[k]; no other bit remapping.
REQ-018 Transmission sequence position n SHALL carry F[n] when Order=0 and F[NUM_WORDS-1-n] when Order=1.
REQ-019 The FSM SHALL have three states: IDLE, SEND and DONE.
REQ-020 IDLE: Start=1 SHALL register INIT and Order in the same edge, clear the position counter to 0 and move to SEND.
REQ-021 SEND: Word_valid=1, Busy=1, Word_idx=n, Word_out = word for position n; first word valid on the cycle after the Start edge (latency 1).
REQ-022 A word SHALL be transferred only on an edge with Word_valid=1 and Word_ready=1; on each transfer n increments by 1.
REQ-023 While Word_ready=0, Word_out, Word_idx and Last SHALL hold stable; there is no timeout.
REQ-024 Last SHALL be 1 exactly when Word_valid=1 and n = NUM_WORDS-1.
REQ-025 Transfer of the last word SHALL move to DONE; the counter SHALL never wrap within a transfer.
REQ-026 DONE: Done=1, Busy=0, Word_valid=0 for exactly one cycle, then unconditional move to IDLE.
REQ-027 Start SHALL be ignored in SEND and DONE; INIT/Order changes after capture SHALL NOT affect the transfer in progress.
REQ-028 Start in the cycle after Done (IDLE) SHALL be accepted normally, so back-to-back transfers are 1 + NUM_WORDS + 1 cycles apart at full ready.
REQ-029 In IDLE and DONE, Word_out SHALL be 16'h0000, Word_idx 0 and Last 0.
REQ-030 With NUM_WORDS=1, the single word SHALL assert Last=1 on its first valid cycle.

Reset
REQ-031 Rst=1 SHALL immediately force IDLE, counter 0, captured registers 0, Word_out 0, Word_valid 0, Word_idx 0, Last 0, Busy 0 and Done 0.
REQ-032 Rst asserted mid-transfer SHALL abort the transfer with no Done pulse; Start is ignored while Rst=1.

Verification
REQ-033 Defaults, INIT=64'h0123456789ABCDEF, Order=0, Word_ready=1, Start pulse -> 0x2301, 0x6745, 0xAB89, 0xEFCD with idx 0..3, Last on the 4th word, Done on the following cycle.
REQ-034 Same INIT with Order=1 -> 0xEFCD, 0xAB89, 0x6745, 0x2301; SWAP_BYTES=0, Order=0 -> 0x0123, 0x4567, 0x89AB, 0xCDEF.
REQ-035 Word_ready toggled randomly, INIT changed and Start re-pulsed mid-transfer -> words stable while stalled, original sequence unchanged, exactly one Done.
REQ-036 INIT_WIDTH=128, INIT=128'h00112233_44556677_8899AABB_CCDDEEFF -> 8 words 0x1100, 0x3322, ..., 0xFFEE, Word_idx 0..7, then Done; INIT_WIDTH=16 -> single word with Last=1.
REQ-037 Rst asserted after the 2nd word transfer -> all outputs 0 asynchronously, no Done; a new Start after Rst release produces a full, correct sequence.
REQ-038 Start asserted in the cycle right after Done -> new transfer accepted, first word valid one cycle later.

Source files
------------

// File: rtl/init_frame_serializer.sv
// Serializes a captured LUT/BRAM INIT vector into 16-bit frame words
// over a valid/ready handshake, optionally byte-swapping each word.
module init_frame_serializer #(
    parameter int INIT_WIDTH = 64,
    parameter bit SWAP_BYTES = 1'b1,
    localparam int NUM_WORDS = INIT_WIDTH / 16,
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [INIT_WIDTH-1:0] INIT,
    input  logic                  Order,
    output logic [15:0]           Word_out,
    output logic                  Word_valid,
    input  logic                  Word_ready,
    output logic [IDX_W-1:0]      Word_idx,
    output logic                  Last,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                  state_q, state_d;
    logic [INIT_WIDTH-1:0]   init_q, init_d;
    logic                    order_q, order_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        pos;
    logic [15:0]             src;
    logic [15:0]             frame;
    logic                    valid;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            init_q  <= '0;
            order_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            order_q <= order_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        order_d = order_q;
        cnt_d   = cnt_q;
        valid   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    init_d  = INIT;
                    order_d = Order;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                valid = 1'b1;
                Busy  = 1'b1;
                if (Word_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Position n maps to source word n, or mirrored for LSW-first order
    always_comb begin
        pos = order_q ? (LAST_IDX - cnt_q) : cnt_q;
        src = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (pos == IDX_W'(k)) begin
                src = init_q[INIT_WIDTH-1-16*k -: 16];
            end
        end
        frame = SWAP_BYTES ? {src[7:0], src[15:8]} : src;
    end

    assign Word_valid = valid;
    assign Word_out   = valid ? frame : 16'h0000;
    assign Word_idx   = valid ? cnt_q : '0;
    assign Last       = valid && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_init_frame_serializer.sv
// Directed bench for init_frame_serializer across width/swap variants.
module tb_init_frame_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         order;
    logic         ready;
    logic [63:0]  init64;
    logic [127:0] init128;
    logic [15:0]  init16;
    logic         start_a, start_b, start_c, start_d;

    logic [15:0]  a_word, b_word, c_word, d_word;
    logic         a_valid, b_valid, c_valid, d_valid;
    logic [1:0]   a_idx, b_idx;
    logic [2:0]   c_idx;
    logic [0:0]   d_idx;
    logic         a_last, b_last, c_last, d_last;
    logic         a_busy, b_busy, c_busy, d_busy;
    logic         a_done, b_done, c_done, d_done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    init_frame_serializer u_a (
        .Clk(clk), .Rst(rst), .Start(start_a), .INIT(init64),
        .Order(order), .Word_out(a_word), .Word_valid(a_valid),
        .Word_ready(ready), .Word_idx(a_idx), .Last(a_last),
        .Busy(a_busy), .Done(a_done)
    );

    init_frame_serializer #(.INIT_WIDTH(64), .SWAP_BYTES(1'b0)) u_b (
        .Clk(clk), .Rst(rst), .Start(start_b), .INIT(init64),
        .Order(order), .Word_out(b_word), .Word_valid(b_valid),
        .Word_ready(ready), .Word_idx(b_idx), .Last(b_last),
        .Busy(b_busy), .Done(b_done)
    );

    init_frame_serializer #(.INIT_WIDTH(128)) u_c (
        .Clk(clk), .Rst(rst), .Start(start_c), .INIT(init128),
        .Order(order), .Word_out(c_word), .Word_valid(c_valid),
        .Word_ready(ready), .Word_idx(c_idx), .Last(c_last),
        .Busy(c_busy), .Done(c_done)
    );

    init_frame_serializer #(.INIT_WIDTH(16)) u_d (
        .Clk(clk), .Rst(rst), .Start(start_d), .INIT(init16),
        .Order(order), .Word_out(d_word), .Word_valid(d_valid),
        .Word_ready(ready), .Word_idx(d_idx), .Last(d_last),
        .Busy(d_busy), .Done(d_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_a(input logic [63:0] iv, input logic ord);
        init64  = iv;
        order   = ord;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic a_seq(input string tag, input logic [63:0] seq);
        for (int n = 0; n < 4; n++) begin
            check({tag, " valid"}, 32'(a_valid), 32'd1);
            check({tag, " busy"}, 32'(a_busy), 32'd1);
            check({tag, " word"}, 32'(a_word), 32'(seq[63-16*n -: 16]));
            check({tag, " idx"}, 32'(a_idx), 32'(n));
            check({tag, " last"}, 32'(a_last), 32'(n == 3));
            @(negedge clk);
        end
        check({tag, " done"}, 32'(a_done), 32'd1);
        check({tag, " done_valid"}, 32'(a_valid), 32'd0);
        check({tag, " done_busy"}, 32'(a_busy), 32'd0);
        check({tag, " done_word"}, 32'(a_word), 32'd0);
        @(negedge clk);
        check({tag, " idle_done"}, 32'(a_done), 32'd0);
        check({tag, " idle_valid"}, 32'(a_valid), 32'd0);
    endtask

    localparam logic [63:0] ORIG = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] SEQ0 = 64'h2301_6745_AB89_EFCD;
    localparam logic [63:0] SEQ1 = 64'hEFCD_AB89_6745_2301;
    localparam logic [127:0] SEQ128 =
        128'h1100_3322_5544_7766_9988_BBAA_DDCC_FFEE;

    initial begin
        int n;
        int dones;
        rst = 1'b1;
        start_a = 0; start_b = 0; start_c = 0; start_d = 0;
        order = 0; ready = 1; init64 = '0; init128 = '0; init16 = '0;
        repeat (2) @(negedge clk);
        check("rst word", 32'(a_word), 32'd0);
        check("rst valid", 32'(a_valid), 32'd0);
        check("rst idx", 32'(a_idx), 32'd0);
        check("rst last", 32'(a_last), 32'd0);
        check("rst busy", 32'(a_busy), 32'd0);
        check("rst done", 32'(a_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        pulse_a(ORIG, 1'b0);
        a_seq("ord0", SEQ0);
        // Start right after Done: back-to-back transfer
        pulse_a(ORIG, 1'b1);
        a_seq("ord1", SEQ1);

        pulse_a(ORIG, 1'b0);
        repeat (4) @(negedge clk);
        check("ign_done done", 32'(a_done), 32'd1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("ign_done valid", 32'(a_valid), 32'd0);
        @(negedge clk);
        check("ign_done idle", 32'(a_valid), 32'd0);

        // Random stalls with INIT/Order/Start disturbed mid-transfer
        pulse_a(ORIG, 1'b0);
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
            check("stall valid", 32'(a_valid), 32'd1);
            check("stall word", 32'(a_word), 32'(SEQ0[63-16*n -: 16]));
            check("stall idx", 32'(a_idx), 32'(n));
            check("stall last", 32'(a_last), 32'(n == 3));
            ready = 1'($urandom_range(0, 1));
            start_a = (cyc == 3);
            if (cyc == 3) init64 = 64'hFFFF_0000_FFFF_0000;
            if (cyc == 5) order = 1'b1;
            @(negedge clk);
            if (ready) n++;
        end
        start_a = 1'b0;
        ready = 1'b1;
        check("stall complete", 32'(n), 32'd4);
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            dones += int'(a_done);
            @(negedge clk);
        end
        check("stall one_done", 32'(dones), 32'd1);
        order = 1'b0;

        // Reset mid-transfer after two words transferred
        pulse_a(ORIG, 1'b0);
        repeat (2) @(negedge clk);
        check("mid idx", 32'(a_idx), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("arst word", 32'(a_word), 32'd0);
        check("arst valid", 32'(a_valid), 32'd0);
        check("arst idx", 32'(a_idx), 32'd0);
        check("arst busy", 32'(a_busy), 32'd0);
        check("arst last", 32'(a_last), 32'd0);
        check("arst done", 32'(a_done), 32'd0);
        start_a = 1'b1;
        @(negedge clk);
        check("arst start_ign", 32'(a_valid), 32'd0);
        check("arst no_done", 32'(a_done), 32'd0);
        rst = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        check("post_rst valid", 32'(a_valid), 32'd0);
        check("post_rst done", 32'(a_done), 32'd0);
        pulse_a(ORIG, 1'b0);
        a_seq("after_rst", SEQ0);

        init64 = ORIG;
        order = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("noswap word", 32'(b_word), 32'(ORIG[63-16*k -: 16]));
            check("noswap idx", 32'(b_idx), 32'(k));
            check("noswap last", 32'(b_last), 32'(k == 3));
            @(negedge clk);
        end
        check("noswap done", 32'(b_done), 32'd1);
        @(negedge clk);

        init128 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("w128 valid", 32'(c_valid), 32'd1);
            check("w128 word", 32'(c_word), 32'(SEQ128[127-16*k -: 16]));
            check("w128 idx", 32'(c_idx), 32'(k));
            check("w128 last", 32'(c_last), 32'(k == 7));
            @(negedge clk);
        end
        check("w128 done", 32'(c_done), 32'd1);
        check("w128 done_valid", 32'(c_valid), 32'd0);
        @(negedge clk);

        init16 = 16'hA55A;
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        check("w16 valid", 32'(d_valid), 32'd1);
        check("w16 word", 32'(d_word), 32'h5AA5);
        check("w16 idx", 32'(d_idx), 32'd0);
        check("w16 last", 32'(d_last), 32'd1);
        @(negedge clk);
        check("w16 done", 32'(d_done), 32'd1);
        check("w16 done_last", 32'(d_last), 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
